// File: rtl/execute_unit_mc.sv
// rtl/execute_unit_mc.sv - execute stage: forwarding, ALU, NZCV flags, E/M register, iterative MUL when EXEC_ITER_MUL_EN is defined
module execute_unit_mc #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ValidE,
  input  logic             FlushE,
  input  logic             StallM,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             PCSrcE,
  input  logic             BranchE,
  input  logic             NoWriteE,
  input  logic             ALUSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUResultM,
  output logic             StallE,
  output logic             ValidM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             PCSrcM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       FlagsOut
);

  logic [WIDTH-1:0] op_a, fwd_b, op_b, alu_res;
  logic [WIDTH:0]   add_full, sub_full;
  logic             alu_c, alu_v, stall_e, cond_ex;
  logic             sel_valid, sel_regwrite, sel_memwrite, sel_pcsrc, sel_branch, sel_nowrite, sel_mul;
  logic             sel_c, sel_v;
  logic [3:0]       sel_cond, flags_q, flags_d;
  logic [1:0]       sel_fw;
  logic [WIDTH-1:0] sel_res, sel_wd;
  logic             valid_m_q, regwrite_m_q, memwrite_m_q, pcsrc_m_q;
  logic [WIDTH-1:0] aluout_m_q, wdata_m_q;

  // Operand forwarding; B is forwarded first, then optionally replaced by the immediate
  always_comb begin
    case (ForwardAE)
      2'b01:   op_a = ResultW;
      2'b10:   op_a = ALUResultM;
      default: op_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
    op_b = ALUSrcE ? ExtImmE : fwd_b;
  end

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle ALU; MUL and the reserved code yield 0 here
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControlE)
      3'b000: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b001: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_ITER_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, wd_q, wd_d;
  logic [10:0]      ctrl_q, ctrl_d;
  logic             stall_raw;

  // Multiplier state and operand/control snapshot
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      wd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      wd_q     <= wd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Multiplier next state: latch on entry, shift-add in BUSY, deliver from DONE; flush wins
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    wd_d      = wd_q;
    ctrl_d    = ctrl_q;
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ValidE && !FlushE && (ALUControlE == 3'b110)) begin
          stall_raw = 1'b1;
          state_d   = S_BUSY;
          cnt_d     = '0;
          acc_d     = '0;
          mcand_d   = op_a;
          mplier_d  = op_b;
          wd_d      = fwd_b;
          ctrl_d    = {RegWriteE, MemWriteE, PCSrcE, BranchE, NoWriteE, CondE, FlagWriteE};
        end
      end
      S_BUSY: begin
        stall_raw = 1'b1;
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (FlushE || !StallM) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_e = stall_raw & ~RESET;
`else
  assign stall_e = 1'b0;
`endif

  assign StallE = stall_e;

  // Select what the E/M register sees: the live E instruction, or the finished MUL
  always_comb begin
    sel_valid    = ValidE & ~FlushE;
    sel_regwrite = RegWriteE;
    sel_memwrite = MemWriteE;
    sel_pcsrc    = PCSrcE;
    sel_branch   = BranchE;
    sel_nowrite  = NoWriteE;
    sel_cond     = CondE;
    sel_fw       = FlagWriteE;
    sel_mul      = (ALUControlE == 3'b110);
    sel_res      = alu_res;
    sel_wd       = fwd_b;
    sel_c        = alu_c;
    sel_v        = alu_v;
`ifdef EXEC_ITER_MUL_EN
    if (state_q == S_DONE) begin
      sel_valid    = ~FlushE;
      sel_regwrite = ctrl_q[10];
      sel_memwrite = ctrl_q[9];
      sel_pcsrc    = ctrl_q[8];
      sel_branch   = ctrl_q[7];
      sel_nowrite  = ctrl_q[6];
      sel_cond     = ctrl_q[5:2];
      sel_fw       = ctrl_q[1:0];
      sel_mul      = 1'b1;
      sel_res      = acc_q;
      sel_wd       = wd_q;
      sel_c        = 1'b0;
      sel_v        = 1'b0;
    end
`endif
  end

  // ARM condition evaluation against the architectural flags
  always_comb begin
    case (sel_cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag update only when a valid, condition-passing instruction is loaded into E/M
  always_comb begin
    flags_d = flags_q;
    if (!StallM && !stall_e && sel_valid && cond_ex) begin
      if (sel_fw[1]) flags_d[3:2] = {sel_res[WIDTH-1], (sel_res == '0)};
      if (sel_fw[0] && !sel_mul) flags_d[1:0] = {sel_c, sel_v};
    end
  end

  // E/M pipeline register: hold on StallM, bubble while E is busy, otherwise load
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      pcsrc_m_q    <= 1'b0;
      aluout_m_q   <= '0;
      wdata_m_q    <= '0;
      flags_q      <= 4'b0000;
    end else begin
      flags_q <= flags_d;
      if (!StallM) begin
        if (stall_e) begin
          valid_m_q    <= 1'b0;
          regwrite_m_q <= 1'b0;
          memwrite_m_q <= 1'b0;
          pcsrc_m_q    <= 1'b0;
        end else begin
          valid_m_q    <= sel_valid;
          regwrite_m_q <= sel_valid & sel_regwrite & cond_ex & ~sel_nowrite;
          memwrite_m_q <= sel_valid & sel_memwrite & cond_ex;
          pcsrc_m_q    <= sel_valid & (sel_pcsrc | sel_branch) & cond_ex;
          aluout_m_q   <= sel_res;
          wdata_m_q    <= sel_wd;
        end
      end
    end
  end

  assign ValidM     = valid_m_q;
  assign RegWriteM  = regwrite_m_q;
  assign MemWriteM  = memwrite_m_q;
  assign PCSrcM     = pcsrc_m_q;
  assign ALUOutM    = aluout_m_q;
  assign WriteDataM = wdata_m_q;
  assign FlagsOut   = flags_q;

endmodule

// File: tb/tb_execute_unit_mc.sv
// tb/tb_execute_unit_mc.sv - directed self-checking bench for execute_unit_mc
module tb_execute_unit_mc;
  localparam int WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             ValidE, FlushE, StallM;
  logic             RegWriteE, MemWriteE, PCSrcE, BranchE, NoWriteE, ALUSrcE;
  logic [2:0]       ALUControlE;
  logic [3:0]       CondE;
  logic [1:0]       FlagWriteE, ForwardAE, ForwardBE;
  logic [WIDTH-1:0] RD1E, RD2E, ExtImmE, ResultW, ALUResultM;
  logic             StallE, ValidM, RegWriteM, MemWriteM, PCSrcM;
  logic [WIDTH-1:0] ALUOutM, WriteDataM;
  logic [3:0]       FlagsOut;

  int checks = 0;
  int failures = 0;

  execute_unit_mc #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET(RESET), .ValidE(ValidE), .FlushE(FlushE), .StallM(StallM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .BranchE(BranchE),
    .NoWriteE(NoWriteE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .CondE(CondE),
    .FlagWriteE(FlagWriteE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ResultW(ResultW), .ALUResultM(ALUResultM),
    .StallE(StallE), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .PCSrcM(PCSrcM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .FlagsOut(FlagsOut)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    ValidE = 0; FlushE = 0; StallM = 0;
    RegWriteE = 0; MemWriteE = 0; PCSrcE = 0; BranchE = 0; NoWriteE = 0; ALUSrcE = 0;
    ALUControlE = 3'b000; CondE = 4'b1110; FlagWriteE = 2'b00;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    RD1E = '0; RD2E = '0; ExtImmE = '0; ResultW = '0; ALUResultM = '0;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    ValidE = 1; ALUControlE = op; RD1E = a; RD2E = b;
  endtask

  initial begin
    int n;
    clear_in();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_validm", ValidM, 0);
    check("rst_regwritem", RegWriteM, 0);
    check("rst_memwritem", MemWriteM, 0);
    check("rst_pcsrcm", PCSrcM, 0);
    check("rst_aluout", ALUOutM, 0);
    check("rst_wdata", WriteDataM, 0);
    check("rst_flags", FlagsOut, 4'b0000);
    check("rst_stalle", StallE, 0);
    RESET = 0;

    // ADD overflow via immediate
    set_op(3'b000, 32'h7FFF_FFFF, 32'h0); ExtImmE = 1; ALUSrcE = 1; FlagWriteE = 2'b11; RegWriteE = 1;
    tick();
    check("add_ovf_res", ALUOutM, 32'h8000_0000);
    check("add_ovf_flags", FlagsOut, 4'b1001);
    check("add_ovf_valid", ValidM, 1);
    check("add_ovf_regwr", RegWriteM, 1);

    // SUB 5-5 sets Z and C
    set_op(3'b001, 5, 5); FlagWriteE = 2'b11;
    tick();
    check("sub_eq_res", ALUOutM, 0);
    check("sub_eq_flags", FlagsOut, 4'b0110);

    // NE fails: no register write, still valid, no flag change
    set_op(3'b000, 1, 2); CondE = 4'b0001; RegWriteE = 1; FlagWriteE = 2'b11;
    tick();
    check("ne_regwr", RegWriteM, 0);
    check("ne_valid", ValidM, 1);
    check("ne_flags", FlagsOut, 4'b0110);
    check("ne_res", ALUOutM, 3);

    // Forwarding from M and W
    set_op(3'b000, 32'hAA, 32'hBB); ForwardAE = 2'b10; ALUResultM = 32'h10;
    ForwardBE = 2'b01; ResultW = 32'h3; RegWriteE = 1;
    tick();
    check("fwd_res", ALUOutM, 32'h13);
    check("fwd_wdata", WriteDataM, 32'h3);
    check("fwd_regwr", RegWriteM, 1);

    // EQ passes: store + branch, MOV B
    set_op(3'b101, 32'h1, 32'h55); CondE = 4'b0000; MemWriteE = 1; BranchE = 1;
    tick();
    check("eq_memwr", MemWriteM, 1);
    check("eq_pcsrc", PCSrcM, 1);
    check("eq_regwr", RegWriteM, 0);
    check("mov_res", ALUOutM, 32'h55);
    check("mov_wdata", WriteDataM, 32'h55);

    // CMP-like SUB 3-5 with NoWrite
    set_op(3'b001, 3, 5); RegWriteE = 1; NoWriteE = 1; FlagWriteE = 2'b11;
    tick();
    check("cmp_res", ALUOutM, 32'hFFFF_FFFE);
    check("cmp_flags", FlagsOut, 4'b1000);
    check("cmp_regwr", RegWriteM, 0);

    // AND under LT (passes), ORR under GE (fails)
    set_op(3'b010, 32'hF0F0, 32'hFF00); CondE = 4'b1011; RegWriteE = 1;
    tick();
    check("and_res", ALUOutM, 32'hF000);
    check("lt_regwr", RegWriteM, 1);
    set_op(3'b011, 32'hF0F0, 32'h0F00); CondE = 4'b1010; RegWriteE = 1;
    tick();
    check("orr_res", ALUOutM, 32'hFFF0);
    check("ge_regwr", RegWriteM, 0);

    // EOR to zero, update N,Z only
    set_op(3'b100, 32'hFF, 32'hFF); FlagWriteE = 2'b10;
    tick();
    check("eor_res", ALUOutM, 0);
    check("eor_flags", FlagsOut, 4'b0100);

    // ADD with carry and overflow
    set_op(3'b000, 32'h8000_0000, 32'h8000_0001); FlagWriteE = 2'b11;
    tick();
    check("addcv_res", ALUOutM, 1);
    check("addcv_flags", FlagsOut, 4'b0011);

`ifdef EXEC_ITER_MUL_EN
    // Iterative MUL: 1 entry + WIDTH busy cycles of stall
    set_op(3'b110, 32'hFFFF, 32'h1_0001); FlagWriteE = 2'b11; RegWriteE = 1;
    n = 0;
    while (StallE === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("mul_stall_cycles", n, 33);
    check("mul_bubble_valid", ValidM, 0);
    tick();
    clear_in();
    #1;
    check("mul_valid", ValidM, 1);
    check("mul_res", ALUOutM, 32'hFFFF_FFFF);
    check("mul_flags", FlagsOut, 4'b1011);
    check("mul_regwr", RegWriteM, 1);
    check("mul_idle_stall", StallE, 0);

    // MUL aborted by flush in BUSY cycle 10
    set_op(3'b110, 7, 9); FlagWriteE = 2'b11; RegWriteE = 1;
    repeat (10) tick();
    FlushE = 1;
    tick();
    clear_in();
    #1;
    check("flush_stalle", StallE, 0);
    check("flush_validm", ValidM, 0);
    tick();
    check("flush_validm2", ValidM, 0);
    check("flush_flags", FlagsOut, 4'b1011);
`else
    // MUL disabled: single-cycle zero result, C,V untouched
    set_op(3'b110, 3, 4); FlagWriteE = 2'b11;
    tick();
    check("mul0_res", ALUOutM, 0);
    check("mul0_flags", FlagsOut, 4'b0111);
    check("mul0_stalle", StallE, 0);
`endif

    // Reserved opcode gives 0
    set_op(3'b000, 2, 2);
    tick();
    check("add4_res", ALUOutM, 4);
    set_op(3'b111, 7, 9); FlagWriteE = 2'b11;
    tick();
    check("rsv_res", ALUOutM, 0);
    check("rsv_flags", FlagsOut, 4'b0100);

    // Flushed instruction becomes a bubble
    set_op(3'b000, 1, 1); FlushE = 1; RegWriteE = 1; FlagWriteE = 2'b11;
    tick();
    check("flush_e_valid", ValidM, 0);
    check("flush_e_regwr", RegWriteM, 0);
    check("flush_e_flags", FlagsOut, 4'b0100);

    // StallM hold
    set_op(3'b000, 1, 2); RegWriteE = 1;
    tick();
    set_op(3'b000, 9, 9); MemWriteE = 1; FlagWriteE = 2'b11; StallM = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_res", ALUOutM, 3);
      check("hold_valid", ValidM, 1);
      check("hold_regwr", RegWriteM, 1);
      check("hold_memwr", MemWriteM, 0);
      check("hold_flags", FlagsOut, 4'b0100);
    end
    StallM = 0;
    tick();
    check("release_res", ALUOutM, 32'h12);
    check("release_memwr", MemWriteM, 1);
    check("release_flags", FlagsOut, 4'b0000);

    // Asynchronous reset in the middle of a MUL
    set_op(3'b110, 3, 5); RegWriteE = 1; FlagWriteE = 2'b11;
    repeat (3) tick();
    #2;
    RESET = 1;
    #1;
    check("arst_stalle", StallE, 0);
    check("arst_validm", ValidM, 0);
    check("arst_regwr", RegWriteM, 0);
    check("arst_aluout", ALUOutM, 0);
    check("arst_wdata", WriteDataM, 0);
    check("arst_flags", FlagsOut, 0);
    tick();
    clear_in();
    RESET = 0;
    tick();
    check("post_rst_stalle", StallE, 0);
    check("post_rst_validm", ValidM, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
